// File: rtl/riscv_ctrl_pkg.sv
// Shared control-flow types and constants for the EX-stage redirect logic.
package riscv_ctrl_pkg;

   typedef enum logic {
      RD_IDLE,
      RD_REDIRECT
   } redir_state_e;

   localparam int PC_INC = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != {W{1'b1}})) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves branches/jumps in EX, holds a PC redirect to fetch until accepted,
// flushes wrong-path stages and keeps saturating perf counters.
module branch_redirect_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ex_valid_i,
   input  logic             ex_branch_i,
   input  logic             ex_jal_i,
   input  logic             ex_jalr_i,
   input  logic             br_taken_i,
   input  logic             pred_taken_i,
   input  logic [XLEN-1:0]  ex_pc_i,
   input  logic [XLEN-1:0]  target_i,
   input  logic             stall_i,
   input  logic             redirect_ready_i,
   input  logic             cnt_clr_i,
   output logic             redirect_valid_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic             flush_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   redir_state_e    state;
   logic            resolve;
   logic            actual_taken;
   logic            is_ctl;
   logic            mispredict;
   logic [XLEN-1:0] fix_pc;

   // Resolution is blocked while a redirect is outstanding; the flush keeps EX empty then.
   assign resolve      = ex_valid_i && !stall_i && (state == RD_IDLE);
   assign actual_taken = ex_jal_i || ex_jalr_i || (ex_branch_i && br_taken_i);
   assign is_ctl       = ex_branch_i || ex_jal_i || ex_jalr_i;
   // JALR is never predicted correctly since its target is unknown in ID.
   assign mispredict   = resolve && is_ctl && (ex_jalr_i || (actual_taken != pred_taken_i));
   assign fix_pc       = actual_taken ? {target_i[XLEN-1:1], 1'b0}
                                      : ex_pc_i + XLEN'(PC_INC);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state            <= RD_IDLE;
         redirect_valid_o <= 1'b0;
         flush_o          <= 1'b0;
         redirect_pc_o    <= '0;
         misalign_o       <= 1'b0;
      end else begin
         misalign_o <= resolve && actual_taken && fix_pc[1];
         case (state)
            RD_IDLE: begin
               if (mispredict) begin
                  state            <= RD_REDIRECT;
                  redirect_valid_o <= 1'b1;
                  flush_o          <= 1'b1;
                  redirect_pc_o    <= fix_pc;
               end
            end
            RD_REDIRECT: begin
               if (redirect_ready_i) begin
                  state            <= RD_IDLE;
                  redirect_valid_o <= 1'b0;
                  flush_o          <= 1'b0;
               end
            end
            default: begin
               state            <= RD_IDLE;
               redirect_valid_o <= 1'b0;
               flush_o          <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr_i),
      .inc_i  (resolve && ex_branch_i),
      .cnt_o  (branch_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_mispred_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr_i),
      .inc_i  (mispredict),
      .cnt_o  (mispred_cnt_o)
   );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed plus randomized bench for branch_redirect_ctrl against a cycle-level reference model.
module tb_branch_redirect_ctrl;

   localparam int XLEN = 32;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk;
   logic            rst_n;
   logic            ex_valid, ex_branch, ex_jal, ex_jalr, br_taken, pred_taken;
   logic [XLEN-1:0] ex_pc, target;
   logic            stall, ready, cnt_clr;
   logic            redirect_valid, flush, misalign;
   logic [XLEN-1:0] redirect_pc;
   logic [CW-1:0]   branch_cnt, mispred_cnt;

   int          n_assert = 0;
   int          n_fail   = 0;

   // reference model state
   bit          m_busy;
   bit          m_mis;
   logic [31:0] m_pc;
   int unsigned m_bcnt, m_mcnt;

   branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .ex_valid_i       (ex_valid),
      .ex_branch_i      (ex_branch),
      .ex_jal_i         (ex_jal),
      .ex_jalr_i        (ex_jalr),
      .br_taken_i       (br_taken),
      .pred_taken_i     (pred_taken),
      .ex_pc_i          (ex_pc),
      .target_i         (target),
      .stall_i          (stall),
      .redirect_ready_i (ready),
      .cnt_clr_i        (cnt_clr),
      .redirect_valid_o (redirect_valid),
      .redirect_pc_o    (redirect_pc),
      .flush_o          (flush),
      .misalign_o       (misalign),
      .branch_cnt_o     (branch_cnt),
      .mispred_cnt_o    (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 32'(redirect_valid), 32'(m_busy));
      check({tag, ".flush"}, 32'(flush), 32'(m_busy));
      if (m_busy) check({tag, ".pc"}, redirect_pc, m_pc);
      check({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
      check({tag, ".branch_cnt"}, 32'(branch_cnt), m_bcnt);
      check({tag, ".mispred_cnt"}, 32'(mispred_cnt), m_mcnt);
   endtask

   task automatic model_reset();
      m_busy = 0;
      m_mis  = 0;
      m_pc   = '0;
      m_bcnt = 0;
      m_mcnt = 0;
   endtask

   // One clock: drive inputs, advance the model, check on the following falling edge.
   task automatic cyc(input string tag, input bit v, br, jal, jalr, bt, pred,
                      input logic [31:0] pc, tgt, input bit st, rdy, clr);
      bit          res, tk, mp;
      logic [31:0] fix;
      ex_valid = v; ex_branch = br; ex_jal = jal; ex_jalr = jalr;
      br_taken = bt; pred_taken = pred; ex_pc = pc; target = tgt;
      stall = st; ready = rdy; cnt_clr = clr;

      res = v && !st && !m_busy;
      tk  = jal || jalr || (br && bt);
      mp  = res && (br || jal || jalr) && (jalr || (tk != pred));
      fix = tk ? (tgt & 32'hFFFF_FFFE) : pc + 32'd4;
      m_mis = res && tk && fix[1];
      if (clr) m_bcnt = 0;
      else if (res && br && m_bcnt < CMAX) m_bcnt++;
      if (clr) m_mcnt = 0;
      else if (mp && m_mcnt < CMAX) m_mcnt++;
      if (m_busy) begin
         if (rdy) m_busy = 0;
      end else if (mp) begin
         m_busy = 1;
         m_pc   = fix;
      end

      @(posedge clk);
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input bit rdy);
      cyc(tag, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, rdy, 0);
   endtask

   initial begin
      int k;
      bit v, st, rdy, clr, bt, pred;
      logic [31:0] pc, tgt;

      rst_n = 1'b0;
      {ex_valid, ex_branch, ex_jal, ex_jalr, br_taken, pred_taken, stall, ready, cnt_clr} = '0;
      ex_pc = '0; target = '0;
      model_reset();
      #2;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: BEQ taken, predicted not-taken, ready right away
      cyc("beq_mp", 1, 1, 0, 0, 1, 0, 32'h100, 32'h140, 0, 0, 0);
      check("beq_pc_const", redirect_pc, 32'h140);
      idle("beq_hs", 1);
      idle("beq_after", 0);

      // 2: BNE not-taken correctly predicted, then mispredicted
      cyc("bne_ok", 1, 1, 0, 0, 0, 0, 32'h180, 32'h1c0, 0, 0, 0);
      cyc("bne_mp", 1, 1, 0, 0, 0, 1, 32'h200, 32'h240, 0, 0, 0);
      check("bne_pc_const", redirect_pc, 32'h204);
      idle("bne_hs", 1);

      // 3: JALR with odd target, ready withheld three cycles
      cyc("jalr", 1, 0, 0, 1, 0, 1, 32'h300, 32'h1235, 0, 0, 0);
      idle("jalr_w1", 0);
      idle("jalr_w2", 0);
      idle("jalr_w3", 1);
      idle("jalr_done", 0);

      // 4: mispredict under stall, then a second one during REDIRECT
      cyc("stall1", 1, 1, 0, 0, 1, 0, 32'h400, 32'h480, 1, 0, 0);
      cyc("stall2", 1, 1, 0, 0, 1, 0, 32'h400, 32'h480, 1, 1, 0);
      cyc("unstall", 1, 1, 0, 0, 1, 0, 32'h400, 32'h480, 0, 0, 0);
      cyc("second", 1, 1, 0, 0, 1, 0, 32'h500, 32'h580, 0, 0, 0);
      cyc("redir_stall", 1, 0, 1, 0, 0, 0, 32'h600, 32'h700, 1, 1, 0);
      idle("s4_end", 0);

      // 5: saturate branch counter, then clear with a simultaneous increment
      for (int i = 0; i < CMAX + 3; i++)
         cyc("sat", 1, 1, 0, 0, 0, 0, 32'h800 + 32'(i * 4), 32'h0, 0, 0, 0);
      check("sat_const", 32'(branch_cnt), 32'(CMAX));
      cyc("clr_inc", 1, 1, 0, 0, 0, 0, 32'h900, 32'h0, 0, 0, 1);
      check("clr_const", 32'(branch_cnt), 32'h0);

      // PC wrap on not-taken mispredict
      cyc("wrap", 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h10, 0, 0, 0);
      idle("wrap_hs", 1);

      // 6: async reset mid-REDIRECT
      cyc("pre_rst", 1, 0, 0, 1, 0, 0, 32'hA00, 32'hB00, 0, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      idle("post_rst", 1);

      // misaligned taken target still redirects
      cyc("misalign", 1, 1, 0, 0, 1, 0, 32'hC00, 32'h102, 0, 0, 0);
      check("mis_const", 32'(misalign), 32'h1);
      idle("mis_hs", 1);
      idle("mis_after", 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         k    = $urandom_range(0, 3);
         v    = ($urandom_range(0, 7) != 0);
         st   = ($urandom_range(0, 4) == 0);
         rdy  = ($urandom_range(0, 2) != 0);
         clr  = ($urandom_range(0, 40) == 0);
         bt   = $urandom_range(0, 1);
         pred = $urandom_range(0, 1);
         pc   = $urandom & 32'hFFFF_FFFC;
         tgt  = $urandom;
         cyc("rand", v, k == 1, k == 2, k == 3, bt, pred, pc, tgt, st, rdy, clr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
